uart_tx_arb: RTL
================

// Module: uart_tx_arb
// PURPOSE
//  Shares one UART transmit line between NREQ on-chip byte sources.
//  Round-robin arbiter selects a source, accepts one byte, serializes it in the board frame format:
//   start, D7..D0 (MSB first), XOR parity, stop, then idle gap.
//  Sits between the system message sources and the uart_tx pin that the rs232 bench model loops back.
// PARAMETERS
//  NREQ      4    number of requesters (2..8)
//  BAUD_DIV  868  clk_sys cycles per bit (100 MHz -> 115200 baud, 8.68 us/bit)
//  GAP_BITS  1    idle-high bit times appended after stop (0..3)
// PORTS
//  clk_sys   in   1       system clock, all logic rising-edge
//  rst_n     in   1       asynchronous active-low reset
//  req_vld   in   NREQ    per-source byte valid
//  req_data  in   NREQ*8  per-source byte; source i at [8*i+7:8*i]
//  req_rdy   out  NREQ    per-source accept; transfer = req_vld[i] & req_rdy[i] at edge
//  uart_tx   out  1       serial line, idle high
//  busy      out  1       frame (incl. gap) in progress
//  gnt_id    out  3       index of source owning current/last frame
//  frm_done  out  1       1-cycle pulse at end of gap (frame complete)
// BEHAVIOUR
//  Reset: uart_tx=1, busy=0, gnt_id=0, frm_done=0, req_rdy=0, rr pointer=NREQ-1, state IDLE.
//  FSM: IDLE -> SEND -> GAP -> IDLE.
//   IDLE: if any req_vld, winner = first set bit searching from (rr_ptr+1) mod NREQ upward.
//    req_rdy[winner]=1 combinationally, all others 0.
//    Same edge: latch byte, gnt_id=winner, rr_ptr=winner, busy=1, go SEND.
//    No req_vld: stay IDLE, req_rdy=0.
//   SEND: shift FRAME_BITS bits, each held exactly BAUD_DIV cycles.
//    Registered uart_tx; start bit appears the cycle after acceptance.
//   GAP: uart_tx=1 for GAP_BITS*BAUD_DIV cycles (skipped if GAP_BITS=0).
//    Last cycle: frm_done=1. Next cycle IDLE, busy=0.
//  req_rdy=0 in SEND/GAP.
//  Min accept-to-accept spacing = (FRAME_BITS+GAP_BITS)*BAUD_DIV+1 cycles.
//  Parity bit = ^data (even parity over 8 data bits).
//  Counters: baud counter ceil(log2(BAUD_DIV)) bits, counts 0..BAUD_DIV-1, wraps; bit counter 4 bits.
//  Boundaries:
//   - req_vld dropped before grant: no transfer, no side effect.
//   - req_data must stay stable while req_vld=1 and unaccepted.
//   - All NREQ valid continuously: grants rotate 0,1,..,NREQ-1,0,...; none starves.
//   - Single source valid continuously: back-to-back frames, spacing as above.
//   - Reset mid-frame: uart_tx=1 immediately (async), frame dropped, no frm_done.
//   - BAUD_DIV<2 unsupported (elaboration error).
// CONFIGURATION
//  `UART_ARB_PARITY_EN defined: FRAME_BITS=11 (start, 8 data, parity, stop); matches rs232 model.
//  Undefined: FRAME_BITS=10, no parity bit; stop follows D0 directly.
// STRUCTURE
//  Shared package uart_pkg:
//   - UART_DATA_W=8, UART_START=1'b0, UART_STOP=1'b1
//   - FRAME_BITS derivation tied to UART_ARB_PARITY_EN
//   - FSM state encoding
//  Sub-module uart_tx_ser: load/shift serializer + baud counter.
//   Ports: ld, data, uart_tx, bit_done, frm_end.
//  Top keeps the arbiter, rr pointer and FSM.
// TESTING (BAUD_DIV=4, GAP_BITS=1, PARITY_EN defined unless noted)
//  1 Reset only -> uart_tx=1, busy=0, req_rdy=0 for 100 cycles.
//  2 Src0 sends 0xAA -> line 0,1,0,1,0,1,0,1,0,0(par),1,1(gap); each bit 4 cycles;
//    frm_done at cycle 48 after accept.
//  3 All 4 valid with 0x10..0x13 -> accept order 0,1,2,3; gnt_id matches; frames back-to-back.
//  4 Src2 continuous 0xFF, src1 raises mid-frame -> next grant src1 (=(2+1) mod 4 search hits 3? no ->
//    order 2,3-skip,1... expect 2 then 1 only if 3 idle: grant src1? no: search from 3 => src1 via wrap) -> verify grant src1 next.
//  5 Assert rst_n=0 during bit D3 -> uart_tx=1 same cycle, no frm_done; after release src0 0x55 frame correct.
//  6 PARITY_EN undefined, send 0x81 -> 10-bit frame 0,1,0,0,0,0,0,0,1,1 then gap; total 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART frame constants, FSM encoding and frame builder.
//             Optional feature macro: UART_ARB_PARITY_EN (adds even parity bit)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int   UART_DATA_W = 8;
    localparam logic UART_START  = 1'b0;
    localparam logic UART_STOP   = 1'b1;

`ifdef UART_ARB_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } uart_state_e;

    // Frame laid out MSB-first in transmission order: start bit in the top bit.
    function automatic logic [FRAME_BITS-1:0] uart_frame(input logic [UART_DATA_W-1:0] d);
`ifdef UART_ARB_PARITY_EN
        return {UART_START, d, ^d, UART_STOP};
`else
        return {UART_START, d, UART_STOP};
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_ser.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ser
//  Purpose  : Load/shift serializer with baud counter; shifts the frame plus
//             the idle gap. Frame length follows macro UART_ARB_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_ser
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 868,
    parameter int GAP_BITS = 1
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic                   ld,
    input  logic [UART_DATA_W-1:0] data,
    output logic                   uart_tx,
    output logic                   bit_done,
    output logic                   frm_end
);

    localparam int              NBITS     = FRAME_BITS + GAP_BITS;
    localparam int              SH_W      = NBITS - 1;
    localparam int              CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]      BIT_LAST  = 4'(NBITS - 1);

    generate
        if (BAUD_DIV < 2) begin : g_baud_chk
            $error("uart_tx_ser: BAUD_DIV must be at least 2");
        end
    endgenerate

    logic             active_q, active_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [3:0]       bit_q, bit_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic             tx_q, tx_d;
    logic             bit_done_q, bit_done_d;
    logic             frm_end_q, frm_end_d;
    logic [FRAME_BITS-1:0] frame_w;
    logic [SH_W-1:0]  load_sh;

    always_comb begin
        frame_w = uart_frame(data);
        load_sh = '1;
        load_sh[SH_W-1 -: FRAME_BITS-1] = frame_w[FRAME_BITS-2:0];

        active_d = active_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        tx_d     = tx_q;

        if (ld) begin
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = '0;
            tx_d     = frame_w[FRAME_BITS-1];
            sh_d     = load_sh;
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                if (bit_q == BIT_LAST) begin
                    active_d = 1'b0;
                    tx_d     = UART_STOP;
                end else begin
                    bit_d = bit_q + 4'd1;
                    tx_d  = sh_q[SH_W-1];
                    sh_d  = {sh_q[SH_W-2:0], 1'b1};
                end
            end else begin
                baud_d = baud_q + CNT_W'(1);
            end
        end

        // Pulses are registered one cycle ahead so they line up with the last
        // cycle of the bit they mark; this is why BAUD_DIV must be >= 2.
        bit_done_d = active_d && (baud_d == BAUD_LAST);
        frm_end_d  = bit_done_d && (bit_d == BIT_LAST);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            baud_q     <= '0;
            bit_q      <= '0;
            sh_q       <= '1;
            tx_q       <= UART_STOP;
            bit_done_q <= 1'b0;
            frm_end_q  <= 1'b0;
        end else begin
            active_q   <= active_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            tx_q       <= tx_d;
            bit_done_q <= bit_done_d;
            frm_end_q  <= frm_end_d;
        end
    end

    assign uart_tx  = tx_q;
    assign bit_done = bit_done_q;
    assign frm_end  = frm_end_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arb
//  Purpose  : Round-robin arbiter sharing one UART TX line among NREQ byte
//             sources. Parity bit enabled by macro UART_ARB_PARITY_EN.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int BAUD_DIV = 868,
    parameter int GAP_BITS = 1
) (
    input  logic                        clk_sys,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_vld,
    input  logic [NREQ*UART_DATA_W-1:0] req_data,
    output logic [NREQ-1:0]             req_rdy,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [2:0]                  gnt_id,
    output logic                        frm_done
);

    localparam logic [2:0] RR_RST   = 3'(NREQ - 1);
    localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 1);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_nreq_chk
            $error("uart_tx_arb: NREQ must be in 2..8");
        end
        if (GAP_BITS < 0 || GAP_BITS > 3) begin : g_gap_chk
            $error("uart_tx_arb: GAP_BITS must be in 0..3");
        end
    endgenerate

    uart_state_e            state_q;
    logic [2:0]             rr_q;
    logic [2:0]             gnt_q;
    logic                   busy_q;
    logic [3:0]             bits_q;

    logic                   found;
    logic [2:0]             win;
    logic [UART_DATA_W-1:0] win_data;
    logic                   accept;
    logic                   bit_done;
    logic                   frm_end;

    // Two passes: first set bit above the pointer, otherwise wrap to the lowest.
    always_comb begin
        found = 1'b0;
        win   = rr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_vld[i] && (3'(i) > rr_q)) begin
                found = 1'b1;
                win   = 3'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_vld[i] && (3'(i) <= rr_q)) begin
                found = 1'b1;
                win   = 3'(i);
            end
        end

        accept   = (state_q == ST_IDLE) && found;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_rdy[i] = accept && (win == 3'(i));
            if (win == 3'(i)) begin
                win_data = req_data[UART_DATA_W*i +: UART_DATA_W];
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= RR_RST;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            bits_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        gnt_q   <= win;
                        rr_q    <= win;
                        busy_q  <= 1'b1;
                        bits_q  <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // frm_end wins here only when there is no gap to send.
                    if (frm_end) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (bit_done) begin
                        bits_q <= bits_q + 4'd1;
                        if (bits_q == STOP_IDX) begin
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (frm_end) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    uart_tx_ser #(
        .BAUD_DIV (BAUD_DIV),
        .GAP_BITS (GAP_BITS)
    ) u_ser (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .ld       (accept),
        .data     (win_data),
        .uart_tx  (uart_tx),
        .bit_done (bit_done),
        .frm_end  (frm_end)
    );

    assign busy     = busy_q;
    assign gnt_id   = gnt_q;
    assign frm_done = frm_end;

endmodule
`default_nettype wire
